// File: rtl/irq_arbiter_pkg.sv
// Shared types for the interrupt arbiter.
// State encoding and id width used by irq_arbiter.
package irq_arbiter_pkg;

  localparam int IRQ_ID_W = 5;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_arb_state_t;

endpackage

// File: rtl/irq_line_sync.sv
// Two-flop synchronizer for a single interrupt line.
// Used by irq_arbiter when IRQ_ARB_SYNC_EN is defined.
module irq_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter with req/ack/complete handshake.
// Define IRQ_ARB_SYNC_EN to synchronize irq_i through two flops.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_IRQ = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  irq_mask_i,
  input  logic [NUM_IRQ-1:0]  irq_edge_i,
  output logic                irq_req_o,
  output logic [IRQ_ID_W-1:0] irq_id_o,
  input  logic                irq_ack_i,
  input  logic                irq_complete_i,
  output logic                irq_busy_o,
  output logic [NUM_IRQ-1:0]  irq_pending_o
);

  logic [NUM_IRQ-1:0] irq_s;

`ifdef IRQ_ARB_SYNC_EN
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_line_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (irq_i[g]),
      .q_o   (irq_s[g])
    );
  end
`else
  assign irq_s = irq_i;
`endif

  irq_arb_state_t      state_q;
  logic                req_q;
  logic                busy_q;
  logic [IRQ_ID_W-1:0] id_q;
  logic [NUM_IRQ-1:0]  prev_q;
  logic [NUM_IRQ-1:0]  pend_q;
  logic [NUM_IRQ-1:0]  pend_d;

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  clr;
  logic [NUM_IRQ-1:0]  live;
  logic [NUM_IRQ-1:0]  cand;
  logic [31:0]         cand_w;
  logic [IRQ_ID_W-1:0] win;
  logic                ack_ok;

  assign ack_ok = (state_q == IRQ_REQ) && irq_ack_i;
  assign rise   = irq_s & ~prev_q;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = ack_ok && (id_q == IRQ_ID_W'(i));
    end
  end

  // A fresh edge on the ack cycle must survive the clear.
  assign pend_d = ((pend_q & ~clr) | rise) & irq_edge_i;

  assign live = (irq_edge_i & (pend_q | rise))
              | (~irq_edge_i & irq_s);
  assign cand = live & irq_mask_i;

  always_comb begin
    cand_w = '0;
    cand_w[NUM_IRQ-1:0] = cand;
  end

  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) win = IRQ_ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= irq_s;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (|cand) begin
            state_q <= IRQ_REQ;
            req_q   <= 1'b1;
            id_q    <= win;
          end
        end
        IRQ_REQ: begin
          if (irq_ack_i) begin
            state_q <= IRQ_SERVICE;
            req_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else if (!cand_w[id_q]) begin
            state_q <= IRQ_IDLE;
            req_q   <= 1'b0;
          end
        end
        IRQ_SERVICE: begin
          if (irq_complete_i) begin
            state_q <= IRQ_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IRQ_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o     = req_q;
  assign irq_busy_o    = busy_q;
  assign irq_id_o      = id_q;
  assign irq_pending_o = (irq_edge_i & pend_q)
                       | (~irq_edge_i & irq_s);

endmodule
